// File: rtl/arms_wb_scoreboard.sv
// arms_wb_scoreboard: writeback scoreboard for the pipelined ARMS CPU.
// Define ARMS_SB_PC_EN to additionally check the instruction address sequence.
module arms_wb_scoreboard #(
  parameter int                DATA_W   = 32,
  parameter int                SEL_W    = 32,
  parameter int                LATENCY  = 4,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter logic [DATA_W-1:0] PC_STEP  = DATA_W'(4)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              issue_valid,
  input  logic              exp_sel_valid,
  input  logic [SEL_W-1:0]  exp_sel,
  input  logic              exp_data_valid,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [SEL_W-1:0]  dselect,
  input  logic [DATA_W-1:0] dbus,
  input  logic [DATA_W-1:0] iaddrbus,
  output logic              chk_valid,
  output logic              sel_err,
  output logic              data_err,
  output logic              pc_err,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  chk_count,
  output logic              busy
);

  typedef struct packed {
    logic              v;
    logic              sv;
    logic [SEL_W-1:0]  sel;
    logic              dv;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             entry_reg [LATENCY];
  entry_t             entry_in  [LATENCY];
  logic [LATENCY-1:0] v_vec;

  assign entry_in[0] = '{v: issue_valid, sv: exp_sel_valid, sel: exp_sel,
                         dv: exp_data_valid, data: exp_data};

  genvar gi;
  generate
    for (gi = 1; gi < LATENCY; gi++) begin : g_link
      assign entry_in[gi] = entry_reg[gi-1];
    end

    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg[gi] <= '0;
        end else if (!hold) begin
          entry_reg[gi] <= entry_in[gi];
        end
      end
      assign v_vec[gi] = entry_reg[gi].v;
    end
  endgenerate

  assign busy = |v_vec;

  // The oldest entry is compared against the buses sampled at the same edge it leaves.
  entry_t tail;
  logic   chk_fire;
  logic   sel_miss;
  logic   data_miss;
  logic   pc_miss;

  assign tail      = entry_reg[LATENCY-1];
  assign chk_fire  = tail.v & (tail.sv | tail.dv);
  assign sel_miss  = chk_fire & tail.sv & (dselect !== tail.sel);
  assign data_miss = chk_fire & tail.dv & (dbus !== tail.data);

`ifdef ARMS_SB_PC_EN
  logic [DATA_W-1:0] pc_exp_reg;

  assign pc_miss = issue_valid & (iaddrbus !== pc_exp_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_exp_reg <= PC_RESET;
    end else if (!hold && issue_valid) begin
      pc_exp_reg <= pc_exp_reg + PC_STEP;
    end
  end
`else
  logic unused_iaddr;

  assign pc_miss      = 1'b0;
  assign unused_iaddr = ^iaddrbus;
`endif

  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W:0]   chk_sum;
  logic [CNT_W-1:0] err_next;
  logic [CNT_W-1:0] chk_next;

  assign err_inc  = {1'b0, sel_miss} + {1'b0, data_miss} + {1'b0, pc_miss};
  assign err_sum  = {1'b0, err_count} + (CNT_W+1)'(err_inc);
  assign chk_sum  = {1'b0, chk_count} + (CNT_W+1)'(chk_fire);
  // Carry out of the widened sum means the counter would wrap, so pin it at all-ones.
  assign err_next = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  assign chk_next = chk_sum[CNT_W] ? '1 : chk_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_valid <= 1'b0;
      sel_err   <= 1'b0;
      data_err  <= 1'b0;
      pc_err    <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
    end else if (hold) begin
      chk_valid <= 1'b0;
      sel_err   <= 1'b0;
      data_err  <= 1'b0;
      pc_err    <= 1'b0;
    end else begin
      chk_valid <= chk_fire;
      sel_err   <= sel_miss;
      data_err  <= data_miss;
      pc_err    <= pc_miss;
      err_count <= err_next;
      chk_count <= chk_next;
    end
  end

  assign mismatch = sel_err | data_err | pc_err;

endmodule

// File: tb/tb_arms_wb_scoreboard.sv
// Self-checking bench for arms_wb_scoreboard: a queue-based model predicts every
// registered output per edge; scenario tasks add targeted checks on top.
module tb_arms_wb_scoreboard;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        issue_valid = 1'b0;
  logic        exp_sel_valid = 1'b0;
  logic [31:0] exp_sel = '0;
  logic        exp_data_valid = 1'b0;
  logic [31:0] exp_data = '0;
  logic [31:0] dselect = '0;
  logic [31:0] dbus = '0;
  logic [31:0] iaddrbus = '0;

  logic        chk_valid, sel_err, data_err, pc_err, mismatch, busy;
  logic [15:0] err_count, chk_count;
  logic        chk_valid2, sel_err2, data_err2, pc_err2, mismatch2, busy2;
  logic [1:0]  err_count2, chk_count2;

  arms_wb_scoreboard dut (
    .clk(clk), .reset(reset), .hold(hold), .issue_valid(issue_valid),
    .exp_sel_valid(exp_sel_valid), .exp_sel(exp_sel),
    .exp_data_valid(exp_data_valid), .exp_data(exp_data),
    .dselect(dselect), .dbus(dbus), .iaddrbus(iaddrbus),
    .chk_valid(chk_valid), .sel_err(sel_err), .data_err(data_err), .pc_err(pc_err),
    .mismatch(mismatch), .err_count(err_count), .chk_count(chk_count), .busy(busy)
  );

  arms_wb_scoreboard #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .hold(hold), .issue_valid(issue_valid),
    .exp_sel_valid(exp_sel_valid), .exp_sel(exp_sel),
    .exp_data_valid(exp_data_valid), .exp_data(exp_data),
    .dselect(dselect), .dbus(dbus), .iaddrbus(iaddrbus),
    .chk_valid(chk_valid2), .sel_err(sel_err2), .data_err(data_err2), .pc_err(pc_err2),
    .mismatch(mismatch2), .err_count(err_count2), .chk_count(chk_count2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v, sv, dv;
    logic [31:0] sel, data;
  } ent_t;

  typedef struct {
    bit          chk, se, de, pe, busy;
    int unsigned ec, cc;
  } res_t;

  ent_t        pend[$];
  res_t        res_q[$];
  int unsigned m_ec, m_cc;
  logic [31:0] pc_m, pc_drv;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic do_reset(input int n);
    ent_t z;
    reset = 1'b1;
    hold = 1'($urandom_range(0, 1));
    issue_valid = 1'b1;
    exp_sel_valid = 1'b1;
    exp_data_valid = 1'b1;
    exp_sel = $urandom;
    exp_data = $urandom;
    dselect = $urandom;
    dbus = $urandom;
    iaddrbus = $urandom;
    repeat (n) begin
      @(posedge clk); #1;
      n_checks++;
      if ({chk_valid, sel_err, data_err, pc_err, mismatch, busy} !== 6'b0 ||
          err_count !== 16'd0 || chk_count !== 16'd0) begin
        n_errors++;
        $display("FAIL reset_state: got flags=%b busy=%b ec=%0d cc=%0d, want all 0",
                 {chk_valid, sel_err, data_err, pc_err, mismatch}, busy, err_count, chk_count);
      end
    end
    reset = 1'b0;
    hold = 1'b0;
    z.v = 0; z.sv = 0; z.dv = 0; z.sel = '0; z.data = '0;
    pend.delete();
    res_q.delete();
    repeat (LAT) pend.push_back(z);
    m_ec = 0; m_cc = 0; pc_m = '0; pc_drv = '0;
  endtask

  // One clock edge: drive inputs, push the model's prediction, pop and compare after the edge.
  task automatic cycle(input string tag, input bit hld, input bit iv, input bit sv,
                       input logic [31:0] sel, input bit dv, input logic [31:0] data,
                       input logic [31:0] osel, input logic [31:0] odata, input bit bad_pc);
    ent_t t, n;
    res_t r, e;
    reset = 1'b0;
    hold = hld;
    issue_valid = iv;
    exp_sel_valid = sv;
    exp_sel = sel;
    exp_data_valid = dv;
    exp_data = data;
    dselect = osel;
    dbus = odata;
    iaddrbus = bad_pc ? pc_drv + 32'd4 : pc_drv;
    r.chk = 0; r.se = 0; r.de = 0; r.pe = 0; r.busy = 0;
    if (!hld) begin
      t = pend.pop_front();
      r.chk = t.v && (t.sv || t.dv);
      r.se = r.chk && t.sv && (osel !== t.sel);
      r.de = r.chk && t.dv && (odata !== t.data);
`ifdef ARMS_SB_PC_EN
      if (iv) begin
        r.pe = (iaddrbus !== pc_m);
        pc_m = pc_m + 32'd4;
      end
`endif
      if (r.chk) m_cc++;
      m_ec += int'(r.se) + int'(r.de) + int'(r.pe);
      if (iv) pc_drv = pc_drv + 32'd4;
      n.v = iv; n.sv = sv; n.sel = sel; n.dv = dv; n.data = data;
      pend.push_back(n);
    end
    foreach (pend[i]) if (pend[i].v) r.busy = 1;
    r.ec = m_ec;
    r.cc = m_cc;
    res_q.push_back(r);
    @(posedge clk); #1;
    e = res_q.pop_front();
    n_checks++;
    if (chk_valid !== e.chk || sel_err !== e.se || data_err !== e.de || pc_err !== e.pe ||
        mismatch !== (e.se | e.de | e.pe) || busy !== e.busy ||
        err_count !== 16'(e.ec) || chk_count !== 16'(e.cc)) begin
      n_errors++;
      $display("FAIL %s: got chk=%b se=%b de=%b pe=%b mm=%b busy=%b ec=%0d cc=%0d want chk=%b se=%b de=%b pe=%b busy=%b ec=%0d cc=%0d",
               tag, chk_valid, sel_err, data_err, pc_err, mismatch, busy, err_count, chk_count,
               e.chk, e.se, e.de, e.pe, e.busy, e.ec, e.cc);
    end
    if (e.chk) $display("txn %s: compared sel_err=%b data_err=%b ec=%0d cc=%0d",
                        tag, sel_err, data_err, err_count, chk_count);
  endtask

  task automatic idle(input string tag, input logic [31:0] osel, input logic [31:0] odata);
    cycle(tag, 0, 0, 0, 32'h0, 0, 32'h0, osel, odata, 0);
  endtask

  task automatic iss(input string tag, input bit sv, input logic [31:0] sel,
                     input bit dv, input logic [31:0] data);
    cycle(tag, 0, 1, sv, sel, dv, data, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset();
    do_reset(2);
    iss("first_nop", 0, 32'h0, 0, 32'h0);
    n_checks++;
    if (pc_err !== 1'b0) begin
      n_errors++;
      $display("FAIL first_pc: got pc_err=%b want 0", pc_err);
    end
  endtask

  task automatic test_match();
    int pulses = 0;
    iss("match_a", 1, 32'h0010_0000, 1, 32'h0000_0AAA);
    pulses += int'(chk_valid);
    iss("match_b", 1, 32'h0000_0001, 1, 32'h0000_0002);
    pulses += int'(chk_valid);
    idle("match_gap", 32'h0, 32'h0);
    pulses += int'(chk_valid);
    idle("match_gap", 32'h0, 32'h0);
    pulses += int'(chk_valid);
    idle("match_chk_a", 32'h0010_0000, 32'h0000_0AAA);
    pulses += int'(chk_valid);
    idle("match_chk_b", 32'h0000_0001, 32'h0000_0002);
    pulses += int'(chk_valid);
    n_checks++;
    if (pulses != 2 || chk_count !== 16'd2 || err_count !== 16'd0 || mismatch !== 1'b0) begin
      n_errors++;
      $display("FAIL match_stream: got pulses=%0d cc=%0d ec=%0d mm=%b want 2 2 0 0",
               pulses, chk_count, err_count, mismatch);
    end
  endtask

  task automatic test_mismatch();
    iss("mm_data", 1, 32'h1, 1, 32'h0000_0AAC);
    repeat (LAT - 1) idle("mm_gap", 32'h0, 32'h0);
    idle("mm_data_chk", 32'h1, 32'h0000_0AAD);
    n_checks++;
    if (data_err !== 1'b1 || sel_err !== 1'b0 || err_count !== 16'd1) begin
      n_errors++;
      $display("FAIL data_mismatch: got de=%b se=%b ec=%0d want 1 0 1", data_err, sel_err, err_count);
    end
    iss("mm_both", 1, 32'h2, 1, 32'h5);
    repeat (LAT - 1) idle("mm_gap", 32'h0, 32'h0);
    idle("mm_both_chk", 32'h4, 32'h6);
    n_checks++;
    if (err_count !== 16'd3 || mismatch !== 1'b1) begin
      n_errors++;
      $display("FAIL both_mismatch: got ec=%0d mm=%b want 3 1", err_count, mismatch);
    end
  endtask

  task automatic test_dont_care();
    iss("nop", 0, 32'h0, 0, 32'h0);
    repeat (LAT - 1) idle("nop_gap", 32'h0, 32'h0);
    idle("nop_chk", 32'h0, 32'hxxxx_xxxx);
    n_checks++;
    if (chk_valid !== 1'b0 || err_count !== 16'd3 || chk_count !== 16'd4) begin
      n_errors++;
      $display("FAIL nop_dont_care: got chk=%b ec=%0d cc=%0d want 0 3 4", chk_valid, err_count, chk_count);
    end
    iss("r31", 1, 32'h8000_0000, 0, 32'h1234_5678);
    repeat (LAT - 1) idle("r31_gap", 32'h0, 32'h0);
    idle("r31_chk", 32'h8000_0000, 32'hxxxx_xxxx);
    n_checks++;
    if (chk_valid !== 1'b1 || mismatch !== 1'b0 || chk_count !== 16'd5) begin
      n_errors++;
      $display("FAIL sel_only: got chk=%b mm=%b cc=%0d want 1 0 5", chk_valid, mismatch, chk_count);
    end
  endtask

  task automatic test_hold_reset();
    bit early;
    iss("hold_issue", 1, 32'h8, 1, 32'h1234);
    repeat (3) cycle("hold", 1, 1, 1, 32'h10, 1, 32'h99, 32'h0, 32'h0, 0);
    idle("hold_run", 32'h0, 32'h0);
    idle("hold_run", 32'h0, 32'h0);
    idle("hold_run", 32'h0, 32'h0);
    early = chk_valid;
    idle("hold_chk", 32'h8, 32'h1234);
    n_checks++;
    if (early !== 1'b0 || chk_valid !== 1'b1 || mismatch !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_delay: got early=%b chk=%b mm=%b want 0 1 0", early, chk_valid, mismatch);
    end
    iss("inflight", 1, 32'h1, 1, 32'h1);
    iss("inflight", 1, 32'h2, 1, 32'h2);
    iss("inflight", 1, 32'h4, 1, 32'h4);
    do_reset(1);
    repeat (5) idle("post_reset", 32'hDEAD, 32'hBEEF);
    n_checks++;
    if (chk_count !== 16'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_inflight: got cc=%0d busy=%b want 0 0", chk_count, busy);
    end
  endtask

  task automatic test_back_to_back_saturate();
    do_reset(1);
    for (int k = 0; k < 9; k++) begin
      cycle("b2b", 0, k < 5, 1, 32'h1, 1, 32'(k), 32'h1, (k >= 4) ? 32'hFFFF : 32'h0, 0);
    end
    n_checks++;
    if (err_count !== 16'd5 || err_count2 !== 2'd3 || chk_count2 !== 2'd3 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL saturate: got ec=%0d ec2=%0d cc2=%0d busy=%b want 5 3 3 0",
               err_count, err_count2, chk_count2, busy);
    end
  endtask

  task automatic test_pc();
    bit any_pe = 0;
    do_reset(1);
    repeat (18) begin
      iss("pc_seq", 0, 32'h0, 0, 32'h0);
      any_pe |= pc_err;
    end
    n_checks++;
    if (any_pe !== 1'b0) begin
      n_errors++;
      $display("FAIL pc_sequence: got pc_err seen=%b want 0", any_pe);
    end
    do_reset(1);
    iss("pc_ok", 0, 32'h0, 0, 32'h0);
    iss("pc_ok", 0, 32'h0, 0, 32'h0);
    cycle("pc_bad", 0, 1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1);
    n_checks++;
`ifdef ARMS_SB_PC_EN
    if (pc_err !== 1'b1 || err_count !== 16'd1) begin
      n_errors++;
      $display("FAIL pc_wrong: got pc_err=%b ec=%0d want 1 1", pc_err, err_count);
    end
`else
    if (pc_err !== 1'b0 || err_count !== 16'd0) begin
      n_errors++;
      $display("FAIL pc_disabled: got pc_err=%b ec=%0d want 0 0", pc_err, err_count);
    end
`endif
    repeat (LAT) idle("pc_drain", 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_dont_care();
    test_hold_reset();
    test_back_to_back_saturate();
    test_pc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/arms_wb_scoreboard.md
# arms_wb_scoreboard

Synthesizable, parametrised writeback scoreboard for the pipelined ARM LEG CPU (32- and 64-bit builds). It records the expected register-select and writeback data for every issued instruction, then checks `dselect`/`dbus` exactly LATENCY enabled cycles later. Optionally it also checks the instruction address sequence. It sits beside the ARMS core in benches and FPGA self-test wrappers and replaces hand-indexed `k-4` checking with an error/check counter pair.

## Interface
Parameters:
- DATA_W, 32, width of `dbus`, `iaddrbus`, expected data
- SEL_W, 32, width of one-hot register select
- LATENCY, 4, enabled cycles from issue to writeback; legal range 1..16
- CNT_W, 16, width of error and check counters
- PC_RESET, 0, expected address of the first issued instruction
- PC_STEP, 4, expected address increment per issue

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  1 = freeze the pipeline model (CPU stall)
- issue_valid  in  1  an instruction is placed on ibus this cycle
- exp_sel_valid  in  1  expected select is meaningful; 0 = don't care
- exp_sel  in  SEL_W  expected one-hot dselect
- exp_data_valid  in  1  expected data is meaningful; 0 = don't care
- exp_data  in  DATA_W  expected writeback data
- dselect  in  SEL_W  observed CPU dselect
- dbus  in  DATA_W  observed CPU dbus
- iaddrbus  in  DATA_W  observed CPU instruction address
- chk_valid  out  1  a comparison was made at the last edge
- sel_err  out  1  select mismatch at the last edge
- data_err  out  1  data mismatch at the last edge
- pc_err  out  1  address mismatch at the last edge
- mismatch  out  1  OR of the three error flags
- err_count  out  CNT_W  saturating error total
- chk_count  out  CNT_W  saturating comparison total
- busy  out  1  at least one expectation is in flight

## Operation
- Model is a LATENCY-entry shift pipeline. Each entry holds {v, sv, sel, dv, data}.
- On an edge with reset=0 and hold=0:
  - entry[0] <= {issue_valid, exp_sel_valid, exp_sel, exp_data_valid, exp_data}
  - entry[i] <= entry[i-1]
  - entry[LATENCY-1] is compared before the shift.
- Comparison fires only when v=1 and at least one of sv or dv is 1:
  - sel_err = sv & (dselect != sel)
  - data_err = dv & (dbus != data)
  - Any X or Z bit on the observed bus counts as a mismatch (4-state compare in simulation).
- err_count increments by the number of error flags asserted at that edge (0..3). chk_count increments by 1 per comparison. Both saturate at all-ones.
- busy = OR of all entry v bits.
- When hold=1, entries, PC model, and counters are frozen, issue_valid is ignored, and all flags deassert.
- Reset dominates hold and issue_valid at the same edge.

## Timing
- Reset values: every output is 0 and every entry v=0. With the macro enabled, pc_exp = PC_RESET.
- An issue sampled at enabled edge t is checked against `dselect`/`dbus` sampled at enabled edge t+LATENCY.
- Flags and counters are registered. They are valid in the cycle after the compare edge and persist for that one cycle only.
- Hold cycles do not count toward LATENCY, so n hold cycles delay the check by n cycles.
- If reset is asserted mid-stream, all in-flight expectations are dropped with no compare. busy=0 after that edge.
- Back-to-back issues every cycle are supported with no bubble.
- After the last issue, busy falls LATENCY enabled edges later.

## Configuration
- ARMS_SB_PC_EN defined:
  - At an enabled edge with issue_valid=1, `iaddrbus` is compared to pc_exp.
  - pc_err = (iaddrbus != pc_exp), and pc_exp <= pc_exp + PC_STEP modulo 2^DATA_W.
  - The PC check does not require v/sv/dv and does not increment chk_count.
- ARMS_SB_PC_EN undefined:
  - pc_exp logic is absent, `iaddrbus` is unused, and pc_err is tied to 0.

## Test plan
- Reset held for 2 edges with issue_valid=1 and garbage buses -> all outputs 0, busy=0. On release, the first issue at PC 0x0 gives no pc_err.
- Match stream: issue {sel=0x00100000, data=0x00000AAA}, then 0x02 to R0 with sel=0x00000001. Drive the matching dselect/dbus 4 edges after each issue -> chk_valid pulses twice, mismatch=0, chk_count=2, err_count=0.
- Mismatch: expect data 0xAAC and observe 0xAAD with the correct select -> data_err=1, sel_err=0. Observing a wrong select and wrong data together -> err_count increases by 2.
- Don't care: NOP issue with sv=dv=0 and dbus=X at the check edge -> chk_valid=0, counters unchanged. An R31 write with sv=1, dv=0 -> only the select is checked.
- Hold and reset: issue, hold for 3 cycles, then run -> check occurs at edge t+7. Reset with 3 entries in flight -> busy=0 next cycle and no further checks. With CNT_W=2, 5 mismatches -> err_count=3.
- PC, macro on: 18 issues with addresses 0x00..0x44 step 4 -> pc_err never set. Presenting 0x0C instead of 0x08 -> pc_err=1, err_count=1. Macro off, same stimulus -> pc_err stays 0.
